// File: rtl/gpu_pkg.sv
// Shared SIMT core definitions: register numbering,
// regfile FSM states and default geometry.
package gpu_pkg;

   localparam int RID_W           = 5;
   localparam int NUM_THREADS_DEF = 16;
   localparam int WARP_SIZE_DEF   = 32;

   localparam logic [RID_W-1:0] REG_ZERO = 5'd0;
   localparam logic [RID_W-1:0] REG_A0   = 5'd10;
   localparam logic [RID_W-1:0] REG_TIDX = 5'd28;
   localparam logic [RID_W-1:0] REG_BIDX = 5'd29;
   localparam logic [RID_W-1:0] REG_BDIM = 5'd30;
   localparam logic [RID_W-1:0] REG_LID  = 5'd31;

   typedef enum logic {
      RF_IDLE,
      RF_CLEAR
   } rf_state_t;

   // True for the writable general registers x1..x27.
   function automatic logic is_gpr(input logic [RID_W-1:0] r);
      return (r != REG_ZERO) && (r < REG_TIDX);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker for RAW hazard detection.
// An issue setting a register wins over a same-cycle writeback.
module reg_scoreboard
   import gpu_pkg::*;
#(
   parameter int NUM_REGS = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             set_en,
   input  logic [RID_W-1:0] set_rd,
   input  logic             clr_en,
   input  logic [RID_W-1:0] clr_rd,
   input  logic [RID_W-1:0] rs1,
   input  logic [RID_W-1:0] rs2,
   output logic             hazard
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;

   // Apply writeback clear first so a same-register issue overrides it.
   always_comb begin
      pending_nxt = pending;
      if (clr_en)
         pending_nxt[clr_rd] = 1'b0;
      if (set_en && is_gpr(set_rd))
         pending_nxt[set_rd] = 1'b1;
   end

   // Pending vector, wiped on reset and kernel launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= '0;
      else if (clear)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   assign hazard = pending[rs1] | pending[rs2]
                 | (set_en & (set_rd != REG_ZERO)
                    & ((set_rd == rs1) | (set_rd == rs2)));

endmodule

// File: rtl/warp_regfile.sv
// Per-thread register file with special registers,
// masked writeback, RAW scoreboard and clear sweep.
module warp_regfile
   import gpu_pkg::*;
#(
   parameter int NUM_THREADS = NUM_THREADS_DEF,
   parameter int NUM_REGS    = 32,
   parameter int DATA_W      = 32,
   parameter int WARP_SIZE   = WARP_SIZE_DEF,
   parameter int TID_W       = $clog2(NUM_THREADS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   launch,
   input  logic [DATA_W-1:0]      launch_bidx,
   input  logic [DATA_W-1:0]      launch_bdim,
   output logic                   busy,
   input  logic [TID_W-1:0]       rd_tid,
   input  logic [RID_W-1:0]       rs1,
   input  logic [RID_W-1:0]       rs2,
   output logic [DATA_W-1:0]      rd1,
   output logic [DATA_W-1:0]      rd2,
   output logic [DATA_W-1:0]      a0,
   input  logic                   iss_en,
   input  logic [RID_W-1:0]       iss_rd,
   output logic                   hazard,
   input  logic                   wr_en,
   input  logic [NUM_THREADS-1:0] wr_mask,
   input  logic [RID_W-1:0]       wr_rd,
   input  logic [DATA_W-1:0]      wr_data
);

   rf_state_t        state;
   rf_state_t        state_nxt;
   logic [RID_W-1:0] clr_idx;
   logic [RID_W-1:0] idx_nxt;
   logic [DATA_W-1:0] bidx;
   logic [DATA_W-1:0] bdim;
   logic [DATA_W-1:0] tidx;
   logic [DATA_W-1:0] lid;
   logic             wr_ok;
   logic             hazard_raw;

   logic [DATA_W-1:0] bank [NUM_THREADS][NUM_REGS];

   assign busy  = (state == RF_CLEAR);
   assign wr_ok = wr_en & ~busy & is_gpr(wr_rd);

   // Sweep sequencing; launch always restarts from index 0.
   always_comb begin
      state_nxt = state;
      idx_nxt   = clr_idx;
      if (launch) begin
         state_nxt = RF_CLEAR;
         idx_nxt   = '0;
      end else if (state == RF_CLEAR) begin
         idx_nxt = clr_idx + 1'b1;
         if (clr_idx == RID_W'(NUM_REGS - 1))
            state_nxt = RF_IDLE;
      end
   end

   // FSM state, sweep index and latched launch values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
         bidx    <= '0;
         bdim    <= DATA_W'(1);
      end else begin
         state   <= state_nxt;
         clr_idx <= idx_nxt;
         if (launch) begin
            bidx <= launch_bidx;
            bdim <= launch_bdim;
         end
      end
   end

   // Bank storage: sweep zeroing or masked writeback, no reset.
   always_ff @(posedge clk) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (busy)
            bank[t][clr_idx] <= '0;
         else if (wr_ok && wr_mask[t])
            bank[t][wr_rd] <= wr_data;
      end
   end

   assign tidx = DATA_W'(rd_tid);
   assign lid  = tidx & DATA_W'(WARP_SIZE - 1);

   function automatic logic [DATA_W-1:0] rsel(
      input logic [RID_W-1:0] rs
   );
      case (rs)
         REG_ZERO: rsel = '0;
         REG_TIDX: rsel = tidx;
         REG_BIDX: rsel = bidx;
         REG_BDIM: rsel = bdim;
         REG_LID:  rsel = lid;
         default:  rsel = bank[rd_tid][rs];
      endcase
   endfunction

   assign rd1 = busy ? '0 : rsel(rs1);
   assign rd2 = busy ? '0 : rsel(rs2);
   assign a0  = busy ? '0 : bank[rd_tid][REG_A0];

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .clear  (launch),
      .set_en (iss_en & ~busy),
      .set_rd (iss_rd),
      .clr_en (wr_en & ~busy),
      .clr_rd (wr_rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .hazard (hazard_raw)
   );

   assign hazard = busy ? 1'b0 : hazard_raw;

endmodule
